// File: rtl/hsv_to_rgb.sv
// Multi-cycle HSV to RGB converter feeding the R/G/B PWM levels.
// One shared 8x8 scaled multiplier is stepped through SF, SFN, P, Q, T before loading the outputs.
module hsv_to_rgb (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [10:0] hue,
  input  logic [7:0]  sat,
  input  logic [7:0]  val,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b,
  output logic        out_valid
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SF   = 3'd1,
    S_SFN  = 3'd2,
    S_P    = 3'd3,
    S_Q    = 3'd4,
    S_T    = 3'd5,
    S_OUT  = 3'd6
  } state_t;

  // (a*b + 255) >> 8: exact at both ends of the range, so m(x,255)=x and m(x,0)=0.
  function automatic logic [7:0] scaled_mul(input logic [7:0] a, input logic [7:0] c);
    logic [16:0] prod;
    prod = ({9'd0, a} * {9'd0, c}) + 17'd255;
    return prod[15:8];
  endfunction

  function automatic logic [2:0] sector_mod6(input logic [2:0] sec);
    logic [2:0] res;
    case (sec)
      3'd6:    res = 3'd0;
      3'd7:    res = 3'd1;
      default: res = sec;
    endcase
    return res;
  endfunction

  state_t     state_q, state_d;
  logic [2:0] sector_q, sector_d;
  logic [7:0] f_q, f_d;
  logic [7:0] s_q, s_d;
  logic [7:0] v_q, v_d;
  logic [7:0] sf_q, sf_d;
  logic [7:0] sfn_q, sfn_d;
  logic [7:0] p_q, p_d;
  logic [7:0] q_q, q_d;
  logic [7:0] t_q, t_d;
  logic [7:0] r_q, r_d;
  logic [7:0] g_q, g_d;
  logic [7:0] b_q, b_d;
  logic       out_valid_q, out_valid_d;
  logic [7:0] mul_a, mul_b, mul_y;
  logic       accept;

  assign in_ready  = (state_q == S_IDLE) && reset_n;
  assign accept    = in_valid && in_ready;
  assign mul_y     = scaled_mul(mul_a, mul_b);
  assign r         = r_q;
  assign g         = g_q;
  assign b         = b_q;
  assign out_valid = out_valid_q;

  // Next-state, multiplier operand select and datapath register updates.
  always_comb begin
    state_d     = state_q;
    sector_d    = sector_q;
    f_d         = f_q;
    s_d         = s_q;
    v_d         = v_q;
    sf_d        = sf_q;
    sfn_d       = sfn_q;
    p_d         = p_q;
    q_d         = q_q;
    t_d         = t_q;
    r_d         = r_q;
    g_d         = g_q;
    b_d         = b_q;
    out_valid_d = 1'b0;
    mul_a       = 8'd0;
    mul_b       = 8'd0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          sector_d = sector_mod6(hue[10:8]);
          f_d      = hue[7:0];
          s_d      = sat;
          v_d      = val;
          state_d  = S_SF;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_SF: begin
        mul_a   = s_q;
        mul_b   = f_q;
        sf_d    = mul_y;
        state_d = S_SFN;
      end
      S_SFN: begin
        mul_a   = s_q;
        mul_b   = 8'd255 - f_q;
        sfn_d   = mul_y;
        state_d = S_P;
      end
      S_P: begin
        mul_a   = v_q;
        mul_b   = 8'd255 - s_q;
        p_d     = mul_y;
        state_d = S_Q;
      end
      S_Q: begin
        mul_a   = v_q;
        mul_b   = 8'd255 - sf_q;
        q_d     = mul_y;
        state_d = S_T;
      end
      S_T: begin
        mul_a   = v_q;
        mul_b   = 8'd255 - sfn_q;
        t_d     = mul_y;
        state_d = S_OUT;
      end
      S_OUT: begin
        // sector is already reduced mod 6 at capture, so only 0..5 reach here
        case (sector_q)
          3'd0:    begin r_d = v_q; g_d = t_q; b_d = p_q; end
          3'd1:    begin r_d = q_q; g_d = v_q; b_d = p_q; end
          3'd2:    begin r_d = p_q; g_d = v_q; b_d = t_q; end
          3'd3:    begin r_d = p_q; g_d = q_q; b_d = v_q; end
          3'd4:    begin r_d = t_q; g_d = p_q; b_d = v_q; end
          3'd5:    begin r_d = v_q; g_d = p_q; b_d = q_q; end
          default: begin r_d = v_q; g_d = t_q; b_d = p_q; end
        endcase
        out_valid_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      sector_q    <= 3'd0;
      f_q         <= 8'd0;
      s_q         <= 8'd0;
      v_q         <= 8'd0;
      sf_q        <= 8'd0;
      sfn_q       <= 8'd0;
      p_q         <= 8'd0;
      q_q         <= 8'd0;
      t_q         <= 8'd0;
      r_q         <= 8'd0;
      g_q         <= 8'd0;
      b_q         <= 8'd0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sector_q    <= sector_d;
      f_q         <= f_d;
      s_q         <= s_d;
      v_q         <= v_d;
      sf_q        <= sf_d;
      sfn_q       <= sfn_d;
      p_q         <= p_d;
      q_q         <= q_d;
      t_q         <= t_d;
      r_q         <= r_d;
      g_q         <= g_d;
      b_q         <= b_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_hsv_to_rgb.sv
// Self-checking bench for hsv_to_rgb: directed colours, random conversions against a
// reference model, a streaming handshake run and a mid-conversion reset.
module tb_hsv_to_rgb;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [10:0] hue;
  logic [7:0]  sat;
  logic [7:0]  val;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  r, g, b;
  logic        out_valid;

  int checks = 0;
  int errors = 0;
  logic [23:0] last_exp = 24'd0;

  hsv_to_rgb dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .hue       (hue),
    .sat       (sat),
    .val       (val),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .r         (r),
    .g         (g),
    .b         (b),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int sm(input int a, input int c);
    return (a * c + 255) / 256;
  endfunction

  // Textbook sector/fraction HSV formulation using the scaled multiply.
  function automatic logic [23:0] ref_rgb(input logic [10:0] h, input logic [7:0] s, input logic [7:0] v);
    int sec, f, vi, sf, sfn, p, q, t, rr, gg, bb;
    sec = int'(h[10:8]) % 6;
    f   = int'(h[7:0]);
    vi  = int'(v);
    sf  = sm(int'(s), f);
    sfn = sm(int'(s), 255 - f);
    p   = sm(vi, 255 - int'(s));
    q   = sm(vi, 255 - sf);
    t   = sm(vi, 255 - sfn);
    case (sec)
      0:       begin rr = vi; gg = t;  bb = p;  end
      1:       begin rr = q;  gg = vi; bb = p;  end
      2:       begin rr = p;  gg = vi; bb = t;  end
      3:       begin rr = p;  gg = q;  bb = vi; end
      4:       begin rr = t;  gg = p;  bb = vi; end
      default: begin rr = vi; gg = p;  bb = q;  end
    endcase
    return {rr[7:0], gg[7:0], bb[7:0]};
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge after the out_valid cycle.
  task automatic convert(input logic [10:0] h, input logic [7:0] s, input logic [7:0] v,
                         input logic [23:0] exp, input string tag);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
    hue = h; sat = s; val = v; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    hue = 11'($urandom); sat = 8'($urandom); val = 8'($urandom);
    for (int k = 0; k < 6; k++) begin
      check({tag, "_busy_ready"}, {31'd0, in_ready}, 32'd0);
      check({tag, "_busy_ov"}, {31'd0, out_valid}, 32'd0);
      check({tag, "_busy_hold"}, {8'd0, r, g, b}, {8'd0, last_exp});
      @(negedge clk);
    end
    check({tag, "_rgb"}, {8'd0, r, g, b}, {8'd0, exp});
    check({tag, "_ov"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_ready_again"}, {31'd0, in_ready}, 32'd1);
    last_exp = exp;
    @(negedge clk);
    check({tag, "_ov_pulse"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_rgb_hold"}, {8'd0, r, g, b}, {8'd0, exp});
  endtask

  logic [23:0] exp_q[$];
  logic [10:0] rh;
  logic [7:0]  rs, rv;
  int          last_acc;
  int          n_acc;
  int          n_out;

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; hue = 11'd0; sat = 8'd0; val = 8'd0;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_ready", {31'd0, in_ready}, 32'd0);
      check("rst_ov", {31'd0, out_valid}, 32'd0);
      check("rst_rgb", {8'd0, r, g, b}, 32'd0);
    end
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", {31'd0, in_ready}, 32'd1);
    check("post_rst_rgb", {8'd0, r, g, b}, 32'd0);

    convert(11'h000, 8'd255, 8'd255, {8'd255, 8'd0,   8'd0},   "red");
    convert(11'h200, 8'd255, 8'd255, {8'd0,   8'd255, 8'd0},   "green");
    convert(11'h400, 8'd255, 8'd255, {8'd0,   8'd0,   8'd255}, "blue");
    convert(11'h080, 8'd255, 8'd255, {8'd255, 8'd128, 8'd0},   "frac");
    convert(11'h700, 8'd255, 8'd255, {8'd255, 8'd255, 8'd0},   "sector7");
    convert(11'h5a3, 8'd0,   8'd200, {8'd200, 8'd200, 8'd200}, "grey");
    convert(11'h3c1, 8'd77,  8'd0,   {8'd0,   8'd0,   8'd0},   "black");

    for (int i = 0; i < 24; i++) begin
      rh = 11'($urandom); rs = 8'($urandom); rv = 8'($urandom);
      convert(rh, rs, rv, ref_rgb(rh, rs, rv), "rand");
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Streaming: in_valid held high with new random inputs every cycle.
    last_acc = -1; n_acc = 0; n_out = 0;
    for (int i = 0; i < 37; i++) begin
      check("stream_ready", {31'd0, in_ready}, {31'd0, (last_acc < 0) || (i - last_acc >= 7)});
      if (out_valid) begin
        n_out++;
        if (exp_q.size() == 0) begin
          check("stream_spurious_ov", 32'd1, 32'd0);
        end else begin
          last_exp = exp_q.pop_front();
          check("stream_rgb", {8'd0, r, g, b}, {8'd0, last_exp});
        end
      end else begin
        check("stream_hold", {8'd0, r, g, b}, {8'd0, last_exp});
      end
      rh = 11'($urandom); rs = 8'($urandom); rv = 8'($urandom);
      hue = rh; sat = rs; val = rv;
      in_valid = (i < 29);
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_rgb(rh, rs, rv));
        last_acc = i;
        n_acc++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("stream_accepts", n_acc, 32'd5);
    check("stream_outs", n_out, 32'd5);
    check("stream_drained", exp_q.size(), 32'd0);

    // Reset asserted so that it is sampled at E3 of a conversion.
    hue = 11'h123; sat = 8'd200; val = 8'd180; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst_rgb", {8'd0, r, g, b}, 32'd0);
    check("midrst_ov", {31'd0, out_valid}, 32'd0);
    check("midrst_ready", {31'd0, in_ready}, 32'd0);
    last_exp = 24'd0;
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("midrst_no_ov", {31'd0, out_valid}, 32'd0);
      check("midrst_hold", {8'd0, r, g, b}, 32'd0);
    end
    rh = 11'($urandom); rs = 8'($urandom); rv = 8'($urandom);
    convert(rh, rs, rv, ref_rgb(rh, rs, rv), "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hsv_to_rgb.md
# hsv_to_rgb

Sequential HSV-to-RGB converter that produces the three 8-bit `level` values driving the per-channel `hsv_pwm` instances (R, G, B) of the mixer. It accepts one HSV colour per valid/ready handshake. The conversion is computed over several cycles with a single shared 8x8 multiplier. The RGB result is held in output registers so the downstream PWMs see stable levels between updates.

## Interface

**Parameters**
- None. Channel width is fixed at 8 bits to match the PWM `level` input.

**Ports**
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset_n`  in  1  synchronous, active-low reset, sampled on `clk`.
- `hue`  in  11  `hue[10:8]` = sector 0..7; `hue[7:0]` = fraction f within the sector.
- `sat`  in  8  saturation s, 0..255.
- `val`  in  8  value v, 0..255.
- `in_valid`  in  1  the HSV inputs are valid.
- `in_ready`  out  1  the block can accept an input this cycle.
- `r`, `g`, `b`  out  8 each  registered RGB levels, fed to the PWM `level` inputs.
- `out_valid`  out  1  one-cycle pulse marking the cycle in which `r/g/b` take a new value.

## Operation

**Accept**
- An input is accepted on a rising edge where `in_valid && in_ready`.
- `hue`, `sat` and `val` are captured into internal registers at that edge.
- Inputs are ignored at all other times.

**Scaled multiply**
- m(a,b) = (a*b + 255) >> 8, computed at 17-bit intermediate width with an 8-bit result.
- Properties: m(x,255) = x, m(x,0) = 0, m(255,255) = 255.

**Sector handling**
- The effective sector is `hue[10:8]` mod 6, so sector 6 maps to 0 and sector 7 maps to 1.

**FSM**
- States: IDLE, SF, SFN, P, Q, T, OUT. The multiplier is used once per state, in order:
  - SF: sf = m(s, f)
  - SFN: sfn = m(s, 255-f)
  - P: p = m(v, 255-s)
  - Q: q = m(v, 255-sf)
  - T: t = m(v, 255-sfn)
  - OUT: load r/g/b according to the sector mapping below, pulse `out_valid`, return to IDLE.
- Transitions: IDLE→SF on accept; each following state advances unconditionally, one per cycle.

**Sector mapping to (r,g,b)**
- 0: (v,t,p)
- 1: (q,v,p)
- 2: (p,v,t)
- 3: (p,q,v)
- 4: (t,p,v)
- 5: (v,p,q)

**Handshake and hold**
- `in_ready` = (state == IDLE) && `reset_n`.
- There is no backpressure on the output side; `out_valid` is informational only.
- `r/g/b` hold their last value indefinitely until the next OUT state.

## Timing

**Reset**
- While `reset_n` is low at a clock edge:
  - state → IDLE
  - `r` = `g` = `b` = 0
  - `out_valid` = 0
  - `in_ready` = 0 combinationally while `reset_n` is low.
- Reset asserted mid-conversion aborts the conversion: the outputs go to 0 and no `out_valid` pulse is produced.

**Latency and throughput**
- With the accept edge as E0, `r/g/b` update at E6 and `out_valid` is high during the cycle following E6.
- `in_ready` is low from the cycle after E0 through the cycle ending at E6, and high again after E6.
- Minimum spacing between accepts is 7 cycles.

**Edge behaviour**
- `in_valid` held high continuously produces back-to-back conversions, one every 7 cycles.
- Input changes while busy have no effect.
- The `out_valid` cycle and the next `in_ready` cycle coincide.
- The outputs are glitch-free: they change only at an OUT edge or at reset.

## Test plan

- **Reset:** hold `reset_n`=0 for 3 cycles, then release → `r`=`g`=`b`=0, `out_valid`=0, `in_ready`=0 during reset and 1 after release.
- **Primary colours:**
  - hue=0x000, s=255, v=255 → (255,0,0) at E6 and `out_valid` pulses once.
  - hue=0x200 → (0,255,0).
  - hue=0x400 → (0,0,255).
- **Fraction and wrap:**
  - hue=0x080, s=255, v=255 → (255,128,0).
  - hue=0x700 (sector 7) → (255,255,0), identical to sector 1.
- **Greyscale:** s=0, v=200, any hue → (200,200,200); v=0 → (0,0,0).
- **Handshake:** `in_valid` held high with changing inputs → accepts exactly every 7 cycles; inputs presented while `in_ready`=0 are ignored; `r/g/b` remain stable between `out_valid` pulses.
- **Mid-operation reset:** assert `reset_n`=0 at E3 of a conversion → outputs 0, no `out_valid` pulse, and the next accept after release converts correctly.
